sigdiv_10: RTL and testbench
============================

Name: sigdiv_10

Overview:
- Sequential radix-2 restoring divider for binary16 significands (10-bit fraction plus hidden bit). It is the inverse-direction companion to the combinational significand multiplier.
- Computes q = floor(a * 2^(Q_W-1) / b) with a sticky bit, for use by the half-precision FP divide datapath ahead of normalise/round.
- Uses a valid/ready handshake on both input and output. Processes one operation at a time and produces one quotient bit per clock.

Parameters:
- SIG_W, 11, significand width including hidden bit.
- GUARD, 3, extra quotient bits below the significand LSB for rounding; Q_W = SIG_W + GUARD (14).

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  operands a, b are valid.
- in_ready  out  1  block can accept operands (state IDLE).
- a  in  SIG_W  dividend significand; any value, including 0.
- b  in  SIG_W  divisor significand; b[SIG_W-1]=1, or b=0.
- out_valid  out  1  result fields are valid.
- out_ready  in  1  consumer accepts the result.
- q  out  Q_W  quotient; weight of bit k is 2^(k-(Q_W-1)).
- sticky  out  1  final remainder is nonzero.
- dz  out  1  divide by zero (b was 0).

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, q=0, sticky=0, dz=0, count=0.
- Inputs are ignored while rst is high. Async assert aborts any operation mid-flight with no partial output.
- States are IDLE, BUSY and DONE. in_ready = (state==IDLE), decoded combinationally from state. out_valid = (state==DONE).
- IDLE: on in_valid&&in_ready at an edge:
  - latch a into r (SIG_W+1 bits, zero-extended) and b into divisor register;
  - set dz_r = (b==0), count=Q_W-1, q=0;
  - go to BUSY.
- BUSY, one iteration per edge:
  - if r >= {0,b}: q[count]=1 and r = r - b; else q[count]=0.
  - Then r = r<<1, dropping the MSB; the invariant r < 2b guarantees no loss.
  - sticky is computed from the pre-shift remainder at the count=0 step: sticky = (remainder after subtract != 0).
  - At count=0, go to DONE; otherwise decrement count.
- Latency: out_valid rises exactly Q_W (14) cycles after the accepting edge.
- DONE: q, sticky and dz are held stable while out_ready=0 (back-pressure, unbounded). On out_ready=1 at an edge, go to IDLE. There is no accept in the same cycle, so throughput is one result per Q_W+2 cycles minimum.
- dz: when dz_r=1, DONE presents q = all ones (14'h3FFF), sticky=1, dz=1. The iteration still runs the full Q_W cycles, so timing is data-independent.
- a=0: q=0, sticky=0, dz=0 (normal path, no special case).
- b≠0 with b[SIG_W-1]=0 is outside contract: q and sticky are unspecified, but timing and handshake are unchanged. The bench must not check values in this case.
- Range: for normalized b, q lies in [2^(Q_W-2), 2^Q_W) when a is also normalized. q[Q_W-1]=1 iff a>=b.
- in_valid/a/b changes during BUSY or DONE have no effect. Operands are sampled only at the accept edge.
- out_ready asserted outside DONE is ignored.

Decomposition:
- Shared package sigdiv_pkg holds:
  - SIG_W and GUARD defaults and the Q_W derivation;
  - state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - the dz quotient constant (all ones).
- One combinational sub-module, sigdiv_step: inputs r and b; outputs qbit and the next unshifted remainder. It implements the compare/subtract with the existing claN carry-lookahead adder on ~b with cin=1; qbit = carry-out.
- Top level holds the FSM, counter, and q/r/sticky registers.

Test Plan:
- a=0x400, b=0x400, accept at edge 0 -> out_valid at edge 14, q=0x2000, sticky=0, dz=0.
- a=0x7FF, b=0x400 -> q=0x3FF8, sticky=0. Then a=0x400, b=0x600 -> q=0x1555, sticky=1.
- a=0x400, b=0x7FF -> q=0x1002, sticky=1. Then a=0x000, b=0x5A5 -> q=0, sticky=0.
- b=0x000, a=0x3C0 -> after 14 cycles q=0x3FFF, sticky=1, dz=1. Next op a=0x400, b=0x400 returns dz=0, q=0x2000.
- Hold out_ready=0 for 5 cycles in DONE -> q, sticky and out_valid stable, in_ready=0. Toggle in_valid with new operands during this window -> the next result reflects only operands accepted after return to IDLE.
- Assert rst at BUSY count=6 -> immediately out_valid=0, in_ready=1, q=0. After release, accept a=0x600, b=0x400 -> q=0x3000, sticky=0, 14 cycles later.

Source files
------------

// File: rtl/sigdiv_pkg.sv
// Shared constants and state encoding for the binary16 significand divider.
package sigdiv_pkg;
  localparam int SIG_W = 11;
  localparam int GUARD = 3;
  localparam int Q_W   = SIG_W + GUARD;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Quotient presented for a zero divisor.
  localparam logic [Q_W-1:0] DZ_Q = '1;
endpackage

// File: rtl/claN.sv
// N-bit carry-lookahead adder: every carry is its own generate/propagate expression.
module claN #(
  parameter int N = 4
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  logic [N-1:0] g, p;
  logic [N:0]   c;

  assign g = x & y;
  assign p = x ^ y;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      logic acc;
      acc = cin;
      for (int j = 0; j <= i; j++) acc = g[j] | (p[j] & acc);
      c[i+1] = acc;
    end
  end

  assign s    = p ^ c[N-1:0];
  assign cout = c[N];
endmodule

// File: rtl/sigdiv_step.sv
// One restoring-division step: trial subtract r - b; the carry-out is the quotient bit.
module sigdiv_step #(
  parameter int SIG_W = 11
) (
  input  logic [SIG_W:0]   r,
  input  logic [SIG_W-1:0] b,
  output logic             qbit,
  output logic [SIG_W:0]   r_next
);
  logic [SIG_W:0] diff;

  claN #(.N(SIG_W+1)) u_sub (
    .x   (r),
    .y   (~{1'b0, b}),
    .cin (1'b1),
    .s   (diff),
    .cout(qbit)
  );

  assign r_next = qbit ? diff : r;
endmodule

// File: rtl/sigdiv_10.sv
// Sequential radix-2 restoring divider: q = floor(a * 2^(Q_W-1) / b) plus sticky, one bit per clock.
module sigdiv_10
  import sigdiv_pkg::*;
#(
  parameter int SIG_W = sigdiv_pkg::SIG_W,
  parameter int GUARD = sigdiv_pkg::GUARD
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SIG_W-1:0]       a,
  input  logic [SIG_W-1:0]       b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SIG_W+GUARD-1:0] q,
  output logic                   sticky,
  output logic                   dz
);
  localparam int QW = SIG_W + GUARD;
  localparam int CW = $clog2(QW);

  state_t          state;
  logic [CW-1:0]   count;
  logic [SIG_W:0]  r;
  logic [SIG_W-1:0] div;
  logic [QW-1:0]   q_r;
  logic            sticky_r, dz_r;
  logic            qbit;
  logic [SIG_W:0]  r_next;

  sigdiv_step #(.SIG_W(SIG_W)) u_step (
    .r     (r),
    .b     (div),
    .qbit  (qbit),
    .r_next(r_next)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign q         = q_r;
  assign sticky    = sticky_r;
  assign dz        = dz_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      r        <= '0;
      div      <= '0;
      q_r      <= '0;
      sticky_r <= 1'b0;
      dz_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          r        <= {1'b0, a};
          div      <= b;
          dz_r     <= (b == '0);
          count    <= CW'(QW - 1);
          q_r      <= '0;
          sticky_r <= 1'b0;
          state    <= BUSY;
        end
        BUSY: begin
          q_r[count] <= qbit;
          // r < 2b holds for normalised b, so the dropped MSB is always zero.
          r <= {r_next[SIG_W-1:0], 1'b0};
          if (count == '0) begin
            state <= DONE;
            if (dz_r) begin
              q_r      <= QW'(DZ_Q);
              sticky_r <= 1'b1;
            end else begin
              sticky_r <= |r_next;
            end
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sigdiv_10.sv
// Scoreboard bench for sigdiv_10: directed cases plus random operands against an arithmetic model.
module tb_sigdiv_10;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [10:0] a, b;
  logic [13:0] q;
  logic        sticky, dz;

  sigdiv_10 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .sticky(sticky), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] q;
    logic        st;
    logic        dz;
    logic        chk;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0, fails = 0;
  int   cyc = 0;
  logic auto_rdy = 1'b0;
  logic done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact integer division of a*2^13 by b.
  function automatic exp_t model(input logic [10:0] ia, input logic [10:0] ib, input logic chk);
    exp_t   e;
    longint num;
    num   = longint'(ia) * 64'd8192;
    e.chk = chk;
    e.acc = 0;
    if (ib == 0) begin
      e.q = 14'h3FFF; e.st = 1'b1; e.dz = 1'b1;
    end else begin
      e.q  = 14'(num / longint'(ib));
      e.st = (num % longint'(ib)) != 0;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Called in the posedge+#1 phase; returns in that phase just after the accepting edge.
  task automatic issue(input logic [10:0] ia, input logic [10:0] ib, input logic chk);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 500) begin @(posedge clk); #1; n++; end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b1; a = ia; b = ib;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e     = model(ia, ib, chk);
    e.acc = cyc;
    sb.push_back(e);
  endtask

  // Monitor: latency on rising out_valid, values at the handshake.
  initial begin
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) prev = 1'b0;
      else begin
        if (out_valid && !prev) begin
          if (sb.size() == 0) check("unexpected_out", 32'd1, 32'd0);
          else check("latency", cyc - sb[0].acc, 32'd14);
        end
        if (out_valid && out_ready && sb.size() > 0) begin
          e = sb.pop_front();
          check("dz", dz, e.dz);
          if (e.chk) begin
            check("q", q, e.q);
            check("sticky", sticky, e.st);
          end
        end
        prev = out_valid;
      end
    end
  end

  initial begin
    fork
      begin
        while (!done) begin
          @(posedge clk); #2;
          if (auto_rdy) out_ready = ($urandom_range(0, 3) != 0);
        end
      end
      begin
        rst = 1'b1; in_valid = 1'b1; a = 11'h400; b = 11'h400; out_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_q", q, 0);
        check("rst_sticky", sticky, 0);
        check("rst_dz", dz, 0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_rst", in_ready, 1);
        auto_rdy = 1'b1;

        issue(11'h400, 11'h400, 1);
        issue(11'h7FF, 11'h400, 1);
        issue(11'h400, 11'h600, 1);
        issue(11'h400, 11'h7FF, 1);
        issue(11'h000, 11'h5A5, 1);
        issue(11'h3C0, 11'h000, 1);
        issue(11'h000, 11'h000, 1);
        issue(11'h400, 11'h400, 1);
        issue(11'h123, 11'h1FF, 0);

        // Back-pressure: result held for 5 cycles while new operands wiggle.
        while (!in_ready) begin @(posedge clk); #1; end
        auto_rdy = 1'b0; out_ready = 1'b0;
        issue(11'h400, 11'h600, 1);
        for (int i = 0; i < 40 && !out_valid; i++) begin @(posedge clk); #1; end
        for (int i = 0; i < 5; i++) begin
          in_valid = i[0]; a = 11'h7FF; b = 11'h400;
          @(negedge clk);
          check("hold_q", q, 14'h1555);
          check("hold_sticky", sticky, 1);
          check("hold_out_valid", out_valid, 1);
          check("hold_in_ready", in_ready, 0);
          @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(11'h400, 11'h400, 1);
        auto_rdy = 1'b1;

        // Abort mid-flight at count=6.
        while (!in_ready) begin @(posedge clk); #1; end
        issue(11'h7FF, 11'h600, 1);
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_q", q, 0);
        sb.delete();
        @(posedge clk); #1 rst = 1'b0;
        issue(11'h600, 11'h400, 1);

        for (int i = 0; i < 40; i++) begin
          logic [10:0] ra, rb;
          ra = ($urandom_range(0, 7) == 0) ? 11'h000 : 11'($urandom);
          rb = ($urandom_range(0, 9) == 0) ? 11'h000 : (11'h400 | 11'($urandom_range(0, 1023)));
          issue(ra, rb, 1);
        end

        for (int i = 0; i < 3000 && (sb.size() != 0 || out_valid); i++) begin @(posedge clk); #1; end
        if (sb.size() != 0) check("drain_timeout", sb.size(), 0);
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    join
  end
endmodule
